cmd_aggregator: RTL and testbench

CMD_AGGREGATOR -- requirements
Module: cmd_aggregator

---
 rtl/cmd_aggregator_pkg.sv | 23 ++
 rtl/cmd_aggregator_resp_fifo.sv | 80 ++++++++
 rtl/cmd_aggregator.sv | 146 ++++++++++++++
 tb/tb_cmd_aggregator.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_aggregator_pkg.sv
// Purpose: types and constants shared by the command aggregator and the
//          command dispatcher (RX/TX state encodings, ACK/NACK bytes).
package cmd_aggregator_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 24;

  localparam logic [BYTE_W-1:0] ACK  = 8'hA5;
  localparam logic [BYTE_W-1:0] NACK = 8'hEE;

  typedef enum logic [1:0] {
    RX_B0,
    RX_B1,
    RX_B2,
    RX_HOLD
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_e;

endpackage

// File: rtl/cmd_aggregator_resp_fifo.sv
// Purpose: response byte FIFO with registered (synchronous) read data.
// Ports:   push_i/wr_data_i write side; pop_i loads rd_data_o on the next edge;
//          full_o/empty_o are registered occupancy flags.
//          A push while full is accepted only if a pop happens in the same cycle.
module resp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array, no reset needed: validity tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, flags and read register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q  <= ptr_inc(rd_ptr_q);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/cmd_aggregator.sv
// Purpose: assembles 3-byte commands from a UART receiver and streams
//          dispatcher response bytes to a UART transmitter through a FIFO.
// Ports:   rx_rdy/rx_data/clr_rx_rdy   UART receive handshake
//          cmd/cmd_rdy/clr_cmd_rdy     command towards the dispatcher
//          resp_data/send_resp/resp_full  responses from the dispatcher
//          tx_data/trmt/tx_done        UART transmit handshake
//          cmd_dropped (pulse), resp_ovf (sticky) error indications
module cmd_aggregator
  import cmd_aggregator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RESP_DEPTH     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [BYTE_W-1:0] resp_data,
  input  logic              send_resp,
  output logic              resp_full,
  output logic [BYTE_W-1:0] tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              cmd_dropped,
  output logic              resp_ovf
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter value seen in the last idle cycle before the partial command is dropped
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 2);

  rx_state_e        rx_state_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_rdy_q;
  logic             cmd_dropped_q;
  logic [TO_W-1:0]  to_cnt_q;

  tx_state_e        tx_state_q;
  logic             trmt_q;
  logic             resp_ovf_q;

  logic             fifo_full, fifo_empty;
  logic             pop_c;

  // Byte acknowledge must land in the same cycle the byte is taken, so it is
  // decoded from state; reset forces it low while the receiver may still be ready.
  assign clr_rx_rdy = rst_n & rx_rdy & (rx_state_q != RX_HOLD);

  // RX command assembly FSM with inter-byte timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q    <= RX_B0;
      cmd_q         <= '0;
      cmd_rdy_q     <= 1'b0;
      cmd_dropped_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      cmd_dropped_q <= 1'b0;
      case (rx_state_q)
        RX_B0: begin
          to_cnt_q <= '0;
          if (rx_rdy) begin
            cmd_q[23:16] <= rx_data;
            rx_state_q   <= RX_B1;
          end
        end
        RX_B1, RX_B2: begin
          // A byte arriving in the timeout cycle takes priority
          if (rx_rdy) begin
            to_cnt_q <= '0;
            if (rx_state_q == RX_B1) begin
              cmd_q[15:8] <= rx_data;
              rx_state_q  <= RX_B2;
            end else begin
              cmd_q[7:0] <= rx_data;
              rx_state_q <= RX_HOLD;
              cmd_rdy_q  <= 1'b1;
            end
          end else if (to_cnt_q == TO_LIMIT) begin
            to_cnt_q      <= '0;
            rx_state_q    <= RX_B0;
            cmd_dropped_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        RX_HOLD: begin
          to_cnt_q <= '0;
          if (clr_cmd_rdy) begin
            cmd_rdy_q  <= 1'b0;
            rx_state_q <= RX_B0;
          end
        end
        default: rx_state_q <= RX_B0;
      endcase
    end
  end

  // Pop whenever the transmitter is idle and a byte is waiting
  assign pop_c = (tx_state_q == TX_IDLE) & ~fifo_empty;

  // TX FSM, transmit strobe and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      trmt_q     <= 1'b0;
      resp_ovf_q <= 1'b0;
    end else begin
      trmt_q <= pop_c;
      if (send_resp && fifo_full && !pop_c) begin
        resp_ovf_q <= 1'b1;
      end
      case (tx_state_q)
        TX_IDLE: if (pop_c)   tx_state_q <= TX_BUSY;
        TX_BUSY: if (tx_done) tx_state_q <= TX_IDLE;
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (BYTE_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (send_resp),
    .wr_data_i (resp_data),
    .pop_i     (pop_c),
    .rd_data_o (tx_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign cmd_dropped = cmd_dropped_q;
  assign trmt        = trmt_q;
  assign resp_full   = fifo_full;
  assign resp_ovf    = resp_ovf_q;

endmodule

// File: tb/tb_cmd_aggregator.sv
// Purpose: self-checking bench for cmd_aggregator: directed scenarios plus a
//          randomized concurrent RX/TX run against a behavioural model.
module tb_cmd_aggregator;

  localparam int TO    = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_full;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        cmd_dropped;
  logic        resp_ovf;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  cmd_aggregator #(
    .TIMEOUT_CYCLES (TO),
    .RESP_DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp_data   (resp_data),
    .send_resp   (send_resp),
    .resp_full   (resp_full),
    .tx_data     (tx_data),
    .trmt        (trmt),
    .tx_done     (tx_done),
    .cmd_dropped (cmd_dropped),
    .resp_ovf    (resp_ovf)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    resp_data = '0; send_resp = 1'b0; tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one byte until the DUT acknowledges it; called at a falling edge,
  // returns at the falling edge after the consuming rising edge.
  task automatic send_byte(input logic [7:0] b, input int budget, output int waited);
    rx_rdy = 1'b1; rx_data = b; waited = 0;
    #1;
    while (!clr_rx_rdy && waited < budget) begin
      @(negedge clk); #1;
      waited++;
    end
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cmd, cmd_rdy, clr_rx_rdy, trmt, tx_data, resp_full, cmd_dropped, resp_ovf} !== 38'd0) begin
      $display("FAIL reset_outputs: got cmd=%h rdy=%b clr=%b trmt=%b txd=%h full=%b drop=%b ovf=%b, want all 0",
               cmd, cmd_rdy, clr_rx_rdy, trmt, tx_data, resp_full, cmd_dropped, resp_ovf);
    end else passes++;
    rx_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cmd_basic();
    int w, wsum;
    wsum = 0;
    send_byte(8'h05, 20, w); wsum += w;
    send_byte(8'h00, 20, w); wsum += w;
    send_byte(8'h03, 20, w); wsum += w;
    checks++;
    if (wsum !== 0) $display("FAIL basic_ack_latency: got %0d stall cycles, want 0", wsum);
    else passes++;
    checks++;
    if ({cmd, cmd_rdy} !== {24'h050003, 1'b1}) $display("FAIL basic_cmd: got %h/%b, want 050003/1", cmd, cmd_rdy);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1) $display("FAIL basic_hold: got cmd_rdy=%b, want 1", cmd_rdy);
    else passes++;
    clear_cmd();
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 24'h050003) $display("FAIL basic_clear: got %b/%h, want 0/050003", cmd_rdy, cmd);
    else passes++;
    // Clearing while a command is only partially assembled must not disturb it
    send_byte(8'hAA, 20, w);
    clear_cmd();
    send_byte(8'hBB, 20, w);
    send_byte(8'hCC, 20, w);
    checks++;
    if ({cmd, cmd_rdy} !== {24'hAABBCC, 1'b1}) $display("FAIL clr_outside_hold: got %h/%b, want AABBCC/1", cmd, cmd_rdy);
    else passes++;
    clear_cmd();
  endtask

  task automatic test_timeout();
    int w, drop_at, pulses;
    send_byte(8'h02, 20, w);
    send_byte(8'h1C, 20, w);
    drop_at = -1; pulses = 0;
    for (int c = 1; c <= 22; c++) begin
      if (cmd_dropped === 1'b1) begin
        pulses++;
        if (drop_at < 0) drop_at = c;
      end
      checks++;
      if (cmd_rdy !== 1'b0) $display("FAIL timeout_no_rdy: cycle %0d got cmd_rdy=%b, want 0", c, cmd_rdy);
      else passes++;
      @(negedge clk);
    end
    checks++;
    if (drop_at !== TO || pulses !== 1)
      $display("FAIL timeout_pulse: got first at %0d count %0d, want at %0d count 1", drop_at, pulses, TO);
    else passes++;
    send_byte(8'h07, 20, w);
    send_byte(8'h00, 20, w);
    send_byte(8'h00, 20, w);
    checks++;
    if ({cmd, cmd_rdy} !== {24'h070000, 1'b1}) $display("FAIL timeout_recover: got %h/%b, want 070000/1", cmd, cmd_rdy);
    else passes++;
    clear_cmd();
    // Byte landing in the very cycle the timeout would fire is kept
    send_byte(8'h11, 20, w);
    send_byte(8'h22, 20, w);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h33, 20, w);
    checks++;
    if ({cmd, cmd_rdy, w} !== {24'h112233, 1'b1, 32'd0})
      $display("FAIL timeout_race: got %h/%b wait=%0d, want 112233/1 wait=0", cmd, cmd_rdy, w);
    else passes++;
    clear_cmd();
  endtask

  task automatic test_back_pressure();
    int w, bad;
    send_byte(8'h01, 20, w);
    send_byte(8'h02, 20, w);
    send_byte(8'h03, 20, w);
    rx_rdy = 1'b1; rx_data = 8'h04; bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (clr_rx_rdy !== 1'b0) bad++;
      @(negedge clk);
    end
    clr_cmd_rdy = 1'b1;
    #1;
    if (clr_rx_rdy !== 1'b0) bad++;
    checks++;
    if (bad !== 0) $display("FAIL bp_stall: got %0d early acks, want 0", bad);
    else passes++;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1;
    checks++;
    if ({clr_rx_rdy, cmd_rdy} !== 2'b10) $display("FAIL bp_release: got clr=%b rdy=%b, want 1/0", clr_rx_rdy, cmd_rdy);
    else passes++;
    @(negedge clk);
    rx_rdy = 1'b0;
    checks++;
    if (cmd !== 24'h040203) $display("FAIL bp_first_byte: got %h, want 040203", cmd);
    else passes++;
    send_byte(8'h05, 20, w);
    send_byte(8'h06, 20, w);
    checks++;
    if ({cmd, cmd_rdy} !== {24'h040506, 1'b1}) $display("FAIL bp_cmd: got %h/%b, want 040506/1", cmd, cmd_rdy);
    else passes++;
    clear_cmd();
  endtask

  task automatic test_resp_single();
    int bad;
    send_resp = 1'b1; resp_data = 8'hA5;
    @(negedge clk);
    send_resp = 1'b0;
    checks++;
    if (trmt !== 1'b0) $display("FAIL resp_n1: got trmt=%b, want 0", trmt);
    else passes++;
    @(negedge clk);
    checks++;
    if ({trmt, tx_data} !== {1'b1, 8'hA5}) $display("FAIL resp_n2: got %b/%h, want 1/a5", trmt, tx_data);
    else passes++;
    send_resp = 1'b1; resp_data = 8'h3C;
    @(negedge clk);
    send_resp = 1'b0;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (trmt !== 1'b0 || tx_data !== 8'hA5) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) $display("FAIL resp_busy_wait: got %0d bad cycles, want 0", bad);
    else passes++;
    pulse_tx_done();
    checks++;
    if (trmt !== 1'b0) $display("FAIL resp_after_done: got trmt=%b, want 0", trmt);
    else passes++;
    @(negedge clk);
    checks++;
    if ({trmt, tx_data} !== {1'b1, 8'h3C}) $display("FAIL resp_second: got %b/%h, want 1/3c", trmt, tx_data);
    else passes++;
    pulse_tx_done();
    // Done while idle is ignored; a fresh byte still gets the normal latency
    tx_done = 1'b1; send_resp = 1'b1; resp_data = 8'h5A;
    @(negedge clk);
    tx_done = 1'b0; send_resp = 1'b0;
    @(negedge clk);
    checks++;
    if ({trmt, tx_data} !== {1'b1, 8'h5A}) $display("FAIL resp_idle_done: got %b/%h, want 1/5a", trmt, tx_data);
    else passes++;
    pulse_tx_done();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int n, bad_lat, extra;
    checks++;
    if (resp_ovf !== 1'b0) $display("FAIL b2b_ovf_start: got %b, want 0", resp_ovf);
    else passes++;
    for (int i = 0; i < 10; i++) begin
      send_resp = 1'b1; resp_data = 8'(i);
      @(negedge clk);
    end
    send_resp = 1'b0;
    checks++;
    if ({resp_full, resp_ovf, tx_data} !== {1'b1, 1'b1, 8'h00})
      $display("FAIL b2b_full: got full=%b ovf=%b txd=%h, want 1/1/00", resp_full, resp_ovf, tx_data);
    else passes++;
    bad_lat = 0;
    for (int k = 1; k <= 8; k++) begin
      pulse_tx_done();
      n = 0;
      while (trmt !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      if (n !== 1) bad_lat++;
      got.push_back(tx_data);
      if (k == 1) begin
        checks++;
        if (resp_full !== 1'b0) $display("FAIL b2b_unfull: got %b, want 0", resp_full);
        else passes++;
      end
    end
    checks++;
    if (bad_lat !== 0) $display("FAIL b2b_latency: got %0d late bytes, want 0", bad_lat);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== 8'(i + 1)) $display("FAIL b2b_order[%0d]: got %h, want %h", i, got[i], 8'(i + 1));
      else passes++;
    end
    pulse_tx_done();
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (trmt === 1'b1) extra++;
      @(negedge clk);
    end
    checks++;
    if ({extra, resp_ovf} !== {32'd0, 1'b1}) $display("FAIL b2b_drain: got extra=%0d ovf=%b, want 0/1", extra, resp_ovf);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int w, bad;
    send_byte(8'h41, 20, w);
    send_byte(8'h42, 20, w);
    send_resp = 1'b1; resp_data = 8'h77;
    @(negedge clk);
    resp_data = 8'h78;
    @(negedge clk);
    send_resp = 1'b0;
    rx_rdy = 1'b1; rx_data = 8'h99;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd, cmd_rdy, clr_rx_rdy, trmt, tx_data, resp_full, cmd_dropped, resp_ovf} !== 38'd0)
      $display("FAIL midreset_outputs: got cmd=%h rdy=%b clr=%b trmt=%b txd=%h full=%b drop=%b ovf=%b, want all 0",
               cmd, cmd_rdy, clr_rx_rdy, trmt, tx_data, resp_full, cmd_dropped, resp_ovf);
    else passes++;
    repeat (2) @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({trmt, cmd_rdy, cmd_dropped, resp_full} !== 4'b0000) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL midreset_quiet: got %0d active cycles, want 0", bad);
    else passes++;
    send_byte(8'h0A, 20, w);
    send_byte(8'h0B, 20, w);
    send_byte(8'h0C, 20, w);
    checks++;
    if ({cmd, cmd_rdy} !== {24'h0A0B0C, 1'b1}) $display("FAIL midreset_cmd: got %h/%b, want 0a0b0c/1", cmd, cmd_rdy);
    else passes++;
    clear_cmd();
  endtask

  // Randomized RX and TX traffic together against a byte-level model
  task automatic test_random_concurrent();
    logic [23:0] m_cmd;
    int          m_got, m_idle, send_pct;
    bit          m_drop, exp_clr;
    logic [7:0]  q[$];
    bit          m_busy, m_ovf, m_trmt;
    logic [7:0]  m_tx;

    do_reset();
    m_cmd = '0; m_got = 0; m_idle = 0; m_drop = 1'b0; exp_clr = 1'b0;
    q.delete(); m_busy = 1'b0; m_ovf = 1'b0; m_trmt = 1'b0; m_tx = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++;
      if ({cmd, cmd_rdy, cmd_dropped} !== {m_cmd, m_got == 3, m_drop})
        $display("FAIL rnd_rx cyc=%0d: got cmd=%h rdy=%b drop=%b, want cmd=%h rdy=%b drop=%b",
                 cyc, cmd, cmd_rdy, cmd_dropped, m_cmd, m_got == 3, m_drop);
      else passes++;
      checks++;
      if ({trmt, tx_data, resp_full, resp_ovf} !== {m_trmt, m_tx, q.size() == DEPTH, m_ovf})
        $display("FAIL rnd_tx cyc=%0d: got trmt=%b txd=%h full=%b ovf=%b, want trmt=%b txd=%h full=%b ovf=%b",
                 cyc, trmt, tx_data, resp_full, resp_ovf, m_trmt, m_tx, q.size() == DEPTH, m_ovf);
      else passes++;

      if (rx_rdy && exp_clr) rx_rdy = 1'b0;
      if (!rx_rdy && $urandom_range(0, 9) == 0) begin
        rx_rdy = 1'b1; rx_data = 8'($urandom);
      end
      clr_cmd_rdy = ($urandom_range(0, 3) == 0);
      send_pct = ((cyc / 500) % 2 == 1) ? 60 : 15;
      send_resp = ($urandom_range(0, 99) < send_pct);
      resp_data = 8'($urandom);
      tx_done = ($urandom_range(0, 4) == 0);
      #1;

      exp_clr = rx_rdy && (m_got < 3);
      checks++;
      if (clr_rx_rdy !== exp_clr) $display("FAIL rnd_clr cyc=%0d: got %b, want %b", cyc, clr_rx_rdy, exp_clr);
      else passes++;

      // Receive side: three bytes per command, drop after TO-1 silent cycles
      m_drop = 1'b0;
      if (m_got == 3) begin
        if (clr_cmd_rdy) m_got = 0;
      end else if (rx_rdy) begin
        m_cmd[8 * (2 - m_got) +: 8] = rx_data;
        m_got++;
        m_idle = 0;
      end else if (m_got > 0) begin
        m_idle++;
        if (m_idle == TO - 1) begin
          m_got = 0; m_idle = 0; m_drop = 1'b1;
        end
      end

      // Transmit side: idle transmitter takes the oldest byte; a full queue
      // accepts a new byte only when one leaves in the same cycle
      m_trmt = 1'b0;
      if (!m_busy && q.size() > 0) begin
        m_tx = q.pop_front();
        m_trmt = 1'b1;
        m_busy = 1'b1;
      end else if (m_busy && tx_done) begin
        m_busy = 1'b0;
      end
      if (send_resp) begin
        if (q.size() < DEPTH) q.push_back(resp_data);
        else m_ovf = 1'b1;
      end

      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_timeout();
    test_back_pressure();
    test_resp_single();
    test_back_to_back();
    test_reset_mid();
    test_random_concurrent();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
